fetch_queue: RTL and testbench

Parametrised N-wide instruction fetch queue that sits between the instruction-memory read ports and decode in the superscalar pipeline. It generalises the fixed 2-wide fetch/decode coupling to WIDTH lanes. It accepts up to WIDTH instructions per cycle with their PCs and presents up to WIDTH oldest instructions per cycle to decode. Decode consumes any in-order prefix of them, so fetch and decode stall independently; a branch redirect flushes the queue.

---
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// N-wide instruction fetch queue: circular buffer of {insn, pc} between imem and decode.
// Latency: an entry written this cycle is visible on deq_* the next cycle; no fall-through.
// Backpressure: enq_ready drops once fewer than WIDTH slots are free; decode takes any in-order prefix.
module fetch_queue #(
    parameter int WIDTH  = 2,
    parameter int DEPTH  = 8,
    parameter int INSN_W = 32,
    parameter int ADDR_W = 12,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int NW    = $clog2(DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [CW-1:0]             enq_count,
    input  logic [WIDTH*INSN_W-1:0]   enq_insn,
    input  logic [ADDR_W-1:0]         enq_pc,
    output logic                      enq_ready,
    output logic [WIDTH-1:0]          deq_valid,
    output logic [WIDTH*INSN_W-1:0]   deq_insn,
    output logic [WIDTH*ADDR_W-1:0]   deq_pc,
    input  logic [CW-1:0]             deq_take,
    output logic [NW-1:0]             count
);

    localparam int PW = $clog2(DEPTH);

    logic [INSN_W-1:0] insn_q [DEPTH];
    logic [INSN_W-1:0] insn_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [NW-1:0]     count_q, count_d;

    logic              enq_fire;
    logic [NW-1:0]     enq_acc;
    logic [NW-1:0]     take_eff;
    logic [PW-1:0]     widx;
    logic [PW-1:0]     ridx;

    // Space check uses the pre-dequeue occupancy, so a same-cycle take never frees room for an enqueue.
    assign enq_ready = (count_q <= NW'(DEPTH - WIDTH));
    assign count     = count_q;

    // Next-state: lane writes at tail+i, clamped take at head, flush overrides both.
    always_comb begin
        enq_fire = enq_ready && (enq_count != '0) && !flush;
        enq_acc  = enq_fire ? NW'(enq_count) : '0;
        take_eff = (NW'(deq_take) > count_q) ? count_q : NW'(deq_take);
        insn_d   = insn_q;
        pc_d     = pc_q;
        widx     = '0;
        head_d   = head_q + PW'(take_eff);
        tail_d   = tail_q + PW'(enq_acc);
        count_d  = count_q + enq_acc - take_eff;
        if (enq_fire) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (CW'(i) < enq_count) begin
                    widx         = tail_q + PW'(i);
                    insn_d[widx] = enq_insn[i*INSN_W +: INSN_W];
                    pc_d[widx]   = enq_pc + ADDR_W'(i);
                end
            end
        end
        // Entry contents are left as-is on flush; only the pointers and occupancy restart.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Read lanes straight from storage at head+i; lanes beyond count show stale data.
    always_comb begin
        deq_valid = '0;
        deq_insn  = '0;
        deq_pc    = '0;
        ridx      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ridx                        = head_q + PW'(i);
            deq_valid[i]                = (count_q > NW'(i));
            deq_insn[i*INSN_W +: INSN_W] = insn_q[ridx];
            deq_pc[i*ADDR_W +: ADDR_W]   = pc_q[ridx];
        end
    end

    // State register; reset clears storage too so idle lanes read as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                insn_q[d] <= '0;
                pc_q[d]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            insn_q  <= insn_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int WIDTH  = 2;
    localparam int DEPTH  = 8;
    localparam int INSN_W = 32;
    localparam int ADDR_W = 12;
    localparam int CW     = $clog2(WIDTH + 1);
    localparam int NW     = $clog2(DEPTH + 1);

    logic                    clock = 0;
    logic                    reset = 1;
    logic                    flush = 0;
    logic [CW-1:0]           enq_count = '0;
    logic [WIDTH*INSN_W-1:0] enq_insn = '0;
    logic [ADDR_W-1:0]       enq_pc = '0;
    logic                    enq_ready;
    logic [WIDTH-1:0]        deq_valid;
    logic [WIDTH*INSN_W-1:0] deq_insn;
    logic [WIDTH*ADDR_W-1:0] deq_pc;
    logic [CW-1:0]           deq_take = '0;
    logic [NW-1:0]           count;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [ADDR_W-1:0] pc;
    } ent_t;

    ent_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INSN_W(INSN_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .enq_count(enq_count), .enq_insn(enq_insn), .enq_pc(enq_pc), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_insn(deq_insn), .deq_pc(deq_pc),
        .deq_take(deq_take), .count(count)
    );

    always #5 clock = ~clock;

    function automatic logic [INSN_W-1:0] mk_insn(input logic [ADDR_W-1:0] pc);
        mk_insn = 32'hC0DE_0000 | 32'(pc);
    endfunction

    // Drive one cycle of stimulus, then update the reference queue at the edge.
    task automatic cyc(input logic fl, input int ec, input logic [INSN_W-1:0] i0,
                       input logic [INSN_W-1:0] i1, input logic [ADDR_W-1:0] pc, input int tk);
        int   te;
        bit   rdy;
        ent_t e;
        flush     = fl;
        enq_count = CW'(ec);
        enq_insn  = {i1, i0};
        enq_pc    = pc;
        deq_take  = CW'(tk);
        @(posedge clock);
        if (fl) begin
            sb.delete();
        end else begin
            rdy = (sb.size() <= DEPTH - WIDTH);
            te  = (tk > sb.size()) ? sb.size() : tk;
            for (int k = 0; k < te; k++) void'(sb.pop_front());
            if (rdy) begin
                for (int k = 0; k < ec; k++) begin
                    e.insn = (k == 0) ? i0 : i1;
                    e.pc   = pc + ADDR_W'(k);
                    sb.push_back(e);
                end
            end
        end
        #1;
        flush = 0; enq_count = '0; deq_take = '0;
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        sb.delete();
        tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count); end
        tests_run++; if (deq_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_deq_valid got %b exp 00", deq_valid); end
        tests_run++; if (enq_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_enq_ready got %b exp 1", enq_ready); end
        tests_run++; if (deq_insn !== '0) begin tests_failed++; $display("FAIL reset_deq_insn got %h exp 0", deq_insn); end
        tests_run++; if (deq_pc !== '0) begin tests_failed++; $display("FAIL reset_deq_pc got %h exp 0", deq_pc); end
    endtask

    task automatic test_enqueue;
        cyc(0, 2, 32'hAAAA0001, 32'hAAAA0002, 12'h010, 0);
        tests_run++; if (deq_valid !== 2'b11) begin tests_failed++; $display("FAIL enq_deq_valid got %b exp 11", deq_valid); end
        tests_run++; if (deq_pc[0 +: ADDR_W] !== 12'h010) begin tests_failed++; $display("FAIL enq_pc0 got %h exp 010", deq_pc[0 +: ADDR_W]); end
        tests_run++; if (deq_pc[ADDR_W +: ADDR_W] !== 12'h011) begin tests_failed++; $display("FAIL enq_pc1 got %h exp 011", deq_pc[ADDR_W +: ADDR_W]); end
        tests_run++; if (deq_insn !== {32'hAAAA0002, 32'hAAAA0001}) begin tests_failed++; $display("FAIL enq_insn got %h exp AAAA0002AAAA0001", deq_insn); end
        tests_run++; if (count !== NW'(2)) begin tests_failed++; $display("FAIL enq_count got %0d exp 2", count); end
    endtask

    task automatic test_fill;
        logic [ADDR_W-1:0] pc;
        cyc(1, 0, '0, '0, '0, 0);
        for (int c = 0; c < 4; c++) begin
            pc = 12'h100 + ADDR_W'(2 * c);
            tests_run++; if (enq_ready !== (sb.size() <= DEPTH - WIDTH)) begin tests_failed++; $display("FAIL fill_ready[%0d] got %b cnt %0d", c, enq_ready, sb.size()); end
            cyc(0, 2, mk_insn(pc), mk_insn(pc + 1), pc, 0);
        end
        tests_run++; if (count !== NW'(8)) begin tests_failed++; $display("FAIL fill_count got %0d exp 8", count); end
        tests_run++; if (enq_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_full_ready got %b exp 0", enq_ready); end
        cyc(0, 2, mk_insn(12'h1F0), mk_insn(12'h1F1), 12'h1F0, 0);
        cyc(0, 1, mk_insn(12'h1F2), '0, 12'h1F2, 0);
        tests_run++; if (count !== NW'(8)) begin tests_failed++; $display("FAIL fill_ignored_count got %0d exp 8", count); end
        tests_run++; if (count !== NW'(sb.size())) begin tests_failed++; $display("FAIL fill_model_count got %0d exp %0d", count, sb.size()); end
    endtask

    task automatic test_wrap;
        logic [ADDR_W-1:0] pc;
        int n;
        tests_run++; if (deq_pc[0 +: ADDR_W] !== sb[0].pc) begin tests_failed++; $display("FAIL wrap_first_pc got %h exp %h", deq_pc[0 +: ADDR_W], sb[0].pc); end
        cyc(0, 0, '0, '0, '0, 1);
        tests_run++; if (count !== NW'(7)) begin tests_failed++; $display("FAIL wrap_take1_count got %0d exp 7", count); end
        tests_run++; if (enq_ready !== 1'b0) begin tests_failed++; $display("FAIL wrap_ready_at7 got %b exp 0", enq_ready); end
        pc = 12'h200;
        for (int c = 0; c < 10; c++) begin
            n = (sb.size() < WIDTH) ? sb.size() : WIDTH;
            for (int k = 0; k < n; k++) begin
                tests_run++; if (deq_pc[k*ADDR_W +: ADDR_W] !== sb[k].pc) begin tests_failed++; $display("FAIL wrap_pc[%0d.%0d] got %h exp %h", c, k, deq_pc[k*ADDR_W +: ADDR_W], sb[k].pc); end
                tests_run++; if (deq_insn[k*INSN_W +: INSN_W] !== sb[k].insn) begin tests_failed++; $display("FAIL wrap_insn[%0d.%0d] got %h exp %h", c, k, deq_insn[k*INSN_W +: INSN_W], sb[k].insn); end
            end
            tests_run++; if (count !== NW'(sb.size())) begin tests_failed++; $display("FAIL wrap_count[%0d] got %0d exp %0d", c, count, sb.size()); end
            tests_run++; if (enq_ready !== (sb.size() <= DEPTH - WIDTH)) begin tests_failed++; $display("FAIL wrap_ready[%0d] got %b", c, enq_ready); end
            // Producer holds its offer until the queue has room.
            if (sb.size() <= DEPTH - WIDTH) begin
                cyc(0, 2, mk_insn(pc), mk_insn(pc + 1), pc, 2);
                pc = pc + 2;
            end else begin
                cyc(0, 2, mk_insn(pc), mk_insn(pc + 1), pc, 2);
            end
        end
    endtask

    task automatic test_overtake;
        cyc(1, 0, '0, '0, '0, 0);
        cyc(0, 1, mk_insn(12'h300), '0, 12'h300, 0);
        tests_run++; if (deq_valid !== 2'b01) begin tests_failed++; $display("FAIL over_valid_pre got %b exp 01", deq_valid); end
        tests_run++; if (deq_pc[0 +: ADDR_W] !== sb[0].pc) begin tests_failed++; $display("FAIL over_pc got %h exp %h", deq_pc[0 +: ADDR_W], sb[0].pc); end
        cyc(0, 0, '0, '0, '0, 2);
        tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL over_count got %0d exp 0", count); end
        tests_run++; if (deq_valid !== 2'b00) begin tests_failed++; $display("FAIL over_valid got %b exp 00", deq_valid); end
    endtask

    task automatic test_flush;
        cyc(1, 0, '0, '0, '0, 0);
        cyc(0, 2, mk_insn(12'h400), mk_insn(12'h401), 12'h400, 0);
        cyc(0, 2, mk_insn(12'h402), mk_insn(12'h403), 12'h402, 0);
        cyc(0, 1, mk_insn(12'h404), '0, 12'h404, 0);
        tests_run++; if (count !== NW'(5)) begin tests_failed++; $display("FAIL flush_pre_count got %0d exp 5", count); end
        cyc(1, 2, mk_insn(12'h500), mk_insn(12'h501), 12'h500, 1);
        tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL flush_count got %0d exp 0", count); end
        tests_run++; if (deq_valid !== 2'b00) begin tests_failed++; $display("FAIL flush_valid got %b exp 00", deq_valid); end
        tests_run++; if (enq_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready got %b exp 1", enq_ready); end
        cyc(0, 0, '0, '0, '0, 0);
        tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL flush_lost_count got %0d exp 0", count); end
        cyc(0, 1, mk_insn(12'h600), '0, 12'h600, 0);
        tests_run++; if (deq_pc[0 +: ADDR_W] !== 12'h600) begin tests_failed++; $display("FAIL flush_after_pc got %h exp 600", deq_pc[0 +: ADDR_W]); end
        tests_run++; if (deq_valid !== 2'b01) begin tests_failed++; $display("FAIL flush_after_valid got %b exp 01", deq_valid); end
    endtask

    task automatic test_back_to_back;
        logic [ADDR_W-1:0] pc;
        cyc(1, 0, '0, '0, '0, 0);
        pc = 12'h700;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < sb.size() && k < WIDTH; k++) begin
                tests_run++; if (deq_pc[k*ADDR_W +: ADDR_W] !== sb[k].pc) begin tests_failed++; $display("FAIL b2b_pc[%0d.%0d] got %h exp %h", c, k, deq_pc[k*ADDR_W +: ADDR_W], sb[k].pc); end
            end
            cyc(0, 2, mk_insn(pc), mk_insn(pc + 1), pc, 2);
            pc = pc + 2;
            tests_run++; if (count !== NW'(2)) begin tests_failed++; $display("FAIL b2b_count[%0d] got %0d exp 2", c, count); end
        end
    endtask

    initial begin
        test_reset;
        test_enqueue;
        test_fill;
        test_wrap;
        test_overtake;
        test_flush;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
